a_flex_fifo_rf: RTL and testbench

Flexible A-operand buffer for the APIR-DSP slice, placed between the A input port and the A/AD pre-adder path. It is the storage read-gated by the mode manager's `MDR` output and enabled by its `LPS` output. It acts as a bypass register (normal mode), a FIFO (low-precision streaming), or a replaying register file (operand reuse). RF/FIFO selection is a static bit shifted in on the slice configuration chain.

---
 rtl/apir_dsp_pkg.sv | 23 ++
 rtl/afifo_ptr_ctrl.sv | 101 ++++++++++
 rtl/a_flex_fifo_rf.sv | 85 ++++++++
 tb/tb_a_flex_fifo_rf.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/apir_dsp_pkg.sv
// Shared APIR-DSP slice types and constants.
// Operand width and A-buffer mode decode.
package apir_dsp_pkg;

  localparam int A_W = 30;

  typedef enum logic [1:0] {
    BYPASS,
    FIFO,
    RF
  } afifo_mode_t;

  function automatic afifo_mode_t afifo_decode(
    input logic lps,
    input logic rfmode
  );
    afifo_mode_t m;
    m = BYPASS;
    if (lps) m = rfmode ? RF : FIFO;
    return m;
  endfunction

endpackage

// File: rtl/afifo_ptr_ctrl.sv
// Pointer, occupancy and error-flag control for the A-operand buffer.
// Sticky flags built only with APIR_AFIFO_ERR_FLAGS_EN defined.
module afifo_ptr_ctrl
  import apir_dsp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  afifo_mode_t      mode,
  input  logic             cea,
  input  logic             mdr,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W-1:0] rp,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             push,
  output logic             pop,
  output logic             rd,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rp_inc;
  logic             store;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign rp_inc = rp + 1'b1;
  assign store  = (mode != BYPASS);

  // Accept/refuse decisions for the current mode
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    rd   = 1'b0;
    unique case (mode)
      FIFO: begin
        pop  = mdr & ~empty;
        push = cea & (~full | pop);
      end
      RF: begin
        rd   = mdr & ~empty;
        push = cea & ~full;
      end
      default: ;
    endcase
  end

  // Pointer and occupancy update; RF reads only move the replay pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head <= head + 1'b1;
        rp   <= head + 1'b1;
      end
      if (rd) rp <= (rp_inc == tail) ? head : rp_inc;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef APIR_AFIFO_ERR_FLAGS_EN
  logic dropped;
  logic refused;

  assign dropped = store & cea & ~push;
  assign refused = store & mdr & empty;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (dropped) overflow  <= 1'b1;
      if (refused) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
  logic unused_store;
  assign unused_store = store;
`endif

endmodule

// File: rtl/a_flex_fifo_rf.sv
// Flexible A-operand buffer: bypass register, FIFO or replaying RF.
// Error flags require APIR_AFIFO_ERR_FLAGS_EN; otherwise tied to 0.
module a_flex_fifo_rf
  import apir_dsp_pkg::*;
#(
  parameter int DATA_W = A_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              RSTAFIFO,
  input  logic [DATA_W-1:0] A_in,
  input  logic              CEA,
  input  logic              LPS,
  input  logic              MDR,
  output logic [DATA_W-1:0] A_out,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow,
  input  logic              configuration_input,
  input  logic              configuration_enable,
  output logic              configuration_output
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rfmode;
  afifo_mode_t       mode;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  rp;
  logic              push;
  logic              pop;
  logic              rd;

  assign mode                 = afifo_decode(LPS, rfmode);
  assign configuration_output = rfmode;

  afifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk       (clk),
    .rst       (RSTAFIFO),
    .mode      (mode),
    .cea       (CEA),
    .mdr       (MDR),
    .head      (head),
    .tail      (tail),
    .rp        (rp),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .push      (push),
    .pop       (pop),
    .rd        (rd),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Config-chain bit; deliberately untouched by the buffer reset
  always_ff @(posedge clk) begin
    if (configuration_enable) rfmode <= configuration_input;
  end

  // Storage write at the tail; contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= A_in;
  end

  // Output register: load in bypass, pop/replay in storage, else hold
  always_ff @(posedge clk) begin
    if (RSTAFIFO) begin
      A_out <= '0;
    end else if (mode == BYPASS) begin
      if (CEA) A_out <= A_in;
    end else if (pop) begin
      A_out <= mem[head];
    end else if (rd) begin
      A_out <= mem[rp];
    end
  end

endmodule

// File: tb/tb_a_flex_fifo_rf.sv
// Self-checking bench for a_flex_fifo_rf.
// Directed vector table plus queue-scoreboard FIFO run.
module tb_a_flex_fifo_rf;

`ifdef APIR_AFIFO_ERR_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RSTAFIFO;
  logic [29:0] A_in;
  logic        CEA, LPS, MDR;
  logic [29:0] A_out;
  logic        full, empty;
  logic [2:0]  count;
  logic        overflow, underflow;
  logic        cfg_in, cfg_en, cfg_out;

  always #5 clk = ~clk;

  a_flex_fifo_rf dut (
    .clk                  (clk),
    .RSTAFIFO             (RSTAFIFO),
    .A_in                 (A_in),
    .CEA                  (CEA),
    .LPS                  (LPS),
    .MDR                  (MDR),
    .A_out                (A_out),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .underflow            (underflow),
    .configuration_input  (cfg_in),
    .configuration_enable (cfg_en),
    .configuration_output (cfg_out)
  );

  typedef struct {
    logic        rst, cfe, cfi, lps, cea, mdr;
    logic [29:0] ain;
    logic [29:0] aout;
    logic [2:0]  cnt;
    logic        ovf, unf, cfg;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic addv(
    input logic rst, cfe, cfi, lps, cea, mdr,
    input logic [29:0] ain, aout,
    input logic [2:0] cnt,
    input logic ovf, unf, cfg
  );
    vec_t v;
    v = '{rst, cfe, cfi, lps, cea, mdr, ain, aout, cnt, ovf, unf, cfg};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, cfe, cfi, lps, cea, mdr,
                       input logic [29:0] ain);
    @(negedge clk);
    RSTAFIFO = rst; cfg_en = cfe; cfg_in = cfi;
    LPS = lps; CEA = cea; MDR = mdr; A_in = ain;
    @(posedge clk);
    #1;
  endtask

  logic [29:0] sb[$];
  logic [29:0] last_a, d, got;
  logic        c, m, pop_m, push_m;

  initial begin
    RSTAFIFO = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0;
    LPS = 1'b0; CEA = 1'b0; MDR = 1'b0; A_in = '0;

    // rst cfe cfi lps cea mdr ain | aout cnt ovf unf cfg
    addv(1,1,0,0,0,0,30'h0,    30'h0,   0,0,0,0);
    addv(0,0,0,0,1,0,30'h1234, 30'h1234,0,0,0,0);
    addv(0,0,0,0,0,1,30'h0,    30'h1234,0,0,0,0);
    for (int k = 1; k <= 4; k++)
      addv(0,0,0,1,1,0,30'(k), 30'h1234,3'(k),0,0,0);
    for (int k = 1; k <= 4; k++)
      addv(0,0,0,1,0,1,30'h0, 30'(k),3'(4-k),0,0,0);
    for (int k = 1; k <= 4; k++)
      addv(0,0,0,1,1,0,30'(k), 30'h4,3'(k),0,0,0);
    addv(0,0,0,1,1,1,30'h5,    30'h1,   4,0,0,0);
    for (int k = 2; k <= 5; k++)
      addv(0,0,0,1,0,1,30'h0, 30'(k),3'(5-k),0,0,0);
    addv(0,0,0,1,1,1,30'hA,    30'h5,   1,0,FL,0);
    addv(0,0,0,1,0,1,30'h0,    30'hA,   0,0,FL,0);
    addv(1,0,0,1,0,0,30'h0,    30'h0,   0,0,0,0);
    addv(0,1,1,0,0,0,30'h0,    30'h0,   0,0,0,1);
    addv(0,0,0,1,1,0,30'h7,    30'h0,   1,0,0,1);
    addv(0,0,0,1,1,0,30'h8,    30'h0,   2,0,0,1);
    addv(0,0,0,1,1,0,30'h9,    30'h0,   3,0,0,1);
    for (int k = 0; k < 7; k++)
      addv(0,0,0,1,0,1,30'h0, 30'(7 + (k % 3)),3,0,0,1);
    addv(0,0,0,1,1,0,30'hB,    30'h7,   4,0,0,1);
    addv(0,0,0,1,1,0,30'hF,    30'h7,   4,FL,0,1);
    addv(0,0,0,1,0,1,30'h0,    30'h8,   4,FL,0,1);
    addv(0,0,0,1,0,1,30'h0,    30'h9,   4,FL,0,1);
    addv(0,0,0,1,0,1,30'h0,    30'hB,   4,FL,0,1);
    addv(0,0,0,1,0,1,30'h0,    30'h7,   4,FL,0,1);
    addv(1,0,0,1,1,1,30'hF,    30'h0,   0,0,0,1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].cfe, vq[i].cfi, vq[i].lps,
            vq[i].cea, vq[i].mdr, vq[i].ain);
      chk("a_out", i, 32'(A_out), 32'(vq[i].aout));
      chk("count", i, 32'(count), 32'(vq[i].cnt));
      chk("empty", i, 32'(empty), 32'(vq[i].cnt == 3'd0));
      chk("full",  i, 32'(full),  32'(vq[i].cnt == 3'd4));
      chk("ovf",   i, 32'(overflow),  32'(vq[i].ovf));
      chk("unf",   i, 32'(underflow), 32'(vq[i].unf));
      chk("cfg",   i, 32'(cfg_out),   32'(vq[i].cfg));
    end

    // Random FIFO traffic against a queue scoreboard
    drive(1, 1, 0, 1, 0, 0, '0);
    last_a = '0;
    for (int i = 0; i < 300; i++) begin
      c = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      d = 30'($urandom);
      pop_m  = m && (sb.size() > 0);
      push_m = c && ((sb.size() < 4) || pop_m);
      if (pop_m) begin
        got    = sb.pop_front();
        last_a = got;
      end
      if (push_m) sb.push_back(d);
      drive(0, 0, 0, 1, c, m, d);
      chk("sb_a_out", i, 32'(A_out), 32'(last_a));
      chk("sb_count", i, 32'(count), 32'(sb.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
